// File: rtl/rc2014_bus_pkg.sv
// Shared encodings for the RC2014 Z80 bus decoder: cycle kinds, FSM states, strobe bit positions.
package rc2014_bus_pkg;

  typedef enum logic [1:0] {
    MEM_RD = 2'd0,
    MEM_WR = 2'd1,
    IO_RD  = 2'd2,
    IO_WR  = 2'd3
  } cyc_kind_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    RESP,
    DRIVE,
    RELEASE,
    SKIP,
    LATE
  } state_t;

  localparam int STROBE_W = 5;
  localparam int S_MRQ    = 0;
  localparam int S_IORQ   = 1;
  localparam int S_RD     = 2;
  localparam int S_WR     = 3;
  localparam int S_M1     = 4;

  function automatic logic is_write(cyc_kind_t k);
    return k[0];
  endfunction

endpackage

// File: rtl/z80_bus_decoder_if.sv
// Z80 pad-side signals plus the transaction/response handshake to the responder stage.
interface z80_bus_decoder_if;
  import rc2014_bus_pkg::*;

  logic [15:0] a;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        mrq;
  logic        iorq;
  logic        rd;
  logic        wr;
  logic        m1;
  logic        wait_n;

  logic        cyc_valid;
  logic        cyc_ready;
  cyc_kind_t   cyc_kind;
  logic [15:0] cyc_addr;
  logic [7:0]  cyc_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        err_late;

  modport master (
    input  a, d_in, mrq, iorq, rd, wr, m1, cyc_ready, rsp_valid, rsp_data,
    output d_out, d_oe, wait_n, cyc_valid, cyc_kind, cyc_addr, cyc_wdata, err_late
  );

  modport slave (
    output a, d_in, mrq, iorq, rd, wr, m1, cyc_ready, rsp_valid, rsp_data,
    input  d_out, d_oe, wait_n, cyc_valid, cyc_kind, cyc_addr, cyc_wdata, err_late
  );

endinterface

// File: rtl/bus_sync.sv
// STAGES-deep synchroniser for one active-low strobe; resets to 1 (strobe inactive).
module bus_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '1;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/z80_bus_decoder.sv
// RC2014 Z80 bus front end: synchronise strobes, qualify/classify cycles, issue transactions,
// drive read data back. Optional read stretching via WAIT_N when RC2014_WAIT_EN is defined.
module z80_bus_decoder
  import rc2014_bus_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] MEM_BASE    = 16'h0000,
  parameter logic [15:0] MEM_SIZE    = 16'h2000,
  parameter logic [7:0]  IO_BASE     = 8'h00,
  parameter logic [7:0]  IO_MASK     = 8'hF8
) (
  input  logic               clk,
  input  logic               rst,
  z80_bus_decoder_if.master  bus
);

`ifdef RC2014_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic [STROBE_W-1:0] raw_n, sync_n, act, prev_act;
  state_t              state;
  logic                oe_reg;
  logic                wait_q;

  assign raw_n = {bus.m1, bus.wr, bus.rd, bus.iorq, bus.mrq};

  for (genvar gi = 0; gi < STROBE_W; gi++) begin : g_sync
    bus_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (raw_n[gi]),
      .q   (sync_n[gi])
    );
  end

  assign act = ~sync_n;

  logic        live, qualified, skip, mem_hit, io_hit;
  logic [16:0] mem_off;
  cyc_kind_t   kind;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    live    = 1'b0;
    skip    = 1'b0;
    mem_off = {1'b0, bus.a} - {1'b0, MEM_BASE};
    mem_hit = 1'b0;
    io_hit  = 1'b0;
    kind    = MEM_RD;

    // A cycle is underway once a space strobe and a direction (or the INTA pattern) are present.
    live = ((act[S_MRQ] | act[S_IORQ]) & (act[S_RD] | act[S_WR]))
         | (act[S_IORQ] & act[S_M1])
         | (act[S_MRQ] & act[S_IORQ]);

    mem_hit = !mem_off[16] && (mem_off[15:0] < MEM_SIZE);
    io_hit  = (bus.a[7:0] & IO_MASK) == (IO_BASE & IO_MASK);
    kind    = cyc_kind_t'({act[S_IORQ], act[S_WR]});

    skip = (act[S_MRQ] & act[S_IORQ])
         | (act[S_IORQ] & act[S_M1])
         | (act[S_RD] & act[S_WR])
         | (act[S_IORQ] ? !io_hit : !mem_hit);
  end

  assign qualified = live && (act == prev_act);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      prev_act      <= '0;
      bus.cyc_valid <= 1'b0;
      bus.cyc_kind  <= MEM_RD;
      bus.cyc_addr  <= '0;
      bus.cyc_wdata <= '0;
      bus.d_out     <= '0;
      oe_reg        <= 1'b0;
      wait_q        <= 1'b1;
      bus.err_late  <= 1'b0;
    end else begin
      prev_act <= act;
      case (state)
        IDLE: begin
          if (qualified) begin
            if (skip) begin
              state <= SKIP;
            end else begin
              state         <= ISSUE;
              bus.cyc_valid <= 1'b1;
              bus.cyc_kind  <= kind;
              bus.cyc_addr  <= bus.a;
              bus.cyc_wdata <= is_write(kind) ? bus.d_in : 8'h00;
              if (WAIT_EN && !is_write(kind)) wait_q <= 1'b0;
            end
          end
        end
        ISSUE: begin
          // cyc_valid is never withdrawn; a released read is caught as late in RESP.
          if (bus.cyc_ready) begin
            bus.cyc_valid <= 1'b0;
            state         <= is_write(bus.cyc_kind) ? RELEASE : RESP;
          end
        end
        RESP: begin
          if (bus.rsp_valid) begin
            wait_q <= 1'b1;
            if (act[S_RD]) begin
              bus.d_out <= bus.rsp_data;
              oe_reg    <= 1'b1;
              state     <= DRIVE;
            end else begin
              bus.err_late <= 1'b1;
              state        <= IDLE;
            end
          end else if (!act[S_RD]) begin
            state <= LATE;
          end
        end
        DRIVE: begin
          if (!act[S_RD]) begin
            oe_reg <= 1'b0;
            state  <= IDLE;
          end
        end
        RELEASE, SKIP: begin
          if (!act[S_MRQ] && !act[S_IORQ]) state <= IDLE;
        end
        LATE: begin
          if (bus.rsp_valid) begin
            bus.err_late <= 1'b1;
            wait_q       <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Raw RD and reset gate the pad enable combinationally so release never causes contention.
  assign bus.d_oe   = oe_reg & ~bus.rd & ~rst;
  assign bus.wait_n = wait_q;

endmodule

// File: tb/tb_z80_bus_decoder.sv
// Directed bench for z80_bus_decoder with a transaction scoreboard; honours RC2014_WAIT_EN.
module tb_z80_bus_decoder;
  import rc2014_bus_pkg::*;

`ifdef RC2014_WAIT_EN
  localparam logic EXP_RD_WAIT = 1'b0;
`else
  localparam logic EXP_RD_WAIT = 1'b1;
`endif

  typedef struct {
    cyc_kind_t   kind;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } exp_t;

  logic clk;
  logic rst;
  z80_bus_decoder_if bus_if ();

  z80_bus_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   n_pushed = 0;
  int   n_accepted = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input cyc_kind_t k, input logic [15:0] a, input logic [7:0] w);
    exp_t e;
    e.kind = k;
    e.addr = a;
    e.wdata = w;
    sb_q.push_back(e);
    n_pushed++;
  endtask

  task automatic strobes(input logic mrq, input logic iorq, input logic rd, input logic wr,
                         input logic m1);
    bus_if.mrq  = mrq;
    bus_if.iorq = iorq;
    bus_if.rd   = rd;
    bus_if.wr   = wr;
    bus_if.m1   = m1;
  endtask

  task automatic respond(input logic [7:0] data);
    bus_if.rsp_valid = 1'b1;
    bus_if.rsp_data  = data;
    tick(1);
    bus_if.rsp_valid = 1'b0;
  endtask

  // Scoreboard: compare each accepted transaction against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus_if.cyc_valid && bus_if.cyc_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_cyc", 32'(bus_if.cyc_valid), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        n_accepted++;
        check("sb_kind",  32'(bus_if.cyc_kind),  32'(mon_e.kind));
        check("sb_addr",  32'(bus_if.cyc_addr),  32'(mon_e.addr));
        check("sb_wdata", 32'(bus_if.cyc_wdata), 32'(mon_e.wdata));
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus_if.a = 16'h0;
    bus_if.d_in = 8'h0;
    strobes(1, 1, 1, 1, 1);
    bus_if.cyc_ready = 1'b1;
    bus_if.rsp_valid = 1'b0;
    bus_if.rsp_data  = 8'h0;
    tick(3);

    check("rst_d_out",     32'(bus_if.d_out),     32'h0);
    check("rst_d_oe",      32'(bus_if.d_oe),      32'h0);
    check("rst_wait_n",    32'(bus_if.wait_n),    32'h1);
    check("rst_cyc_valid", 32'(bus_if.cyc_valid), 32'h0);
    check("rst_cyc_kind",  32'(bus_if.cyc_kind),  32'h0);
    check("rst_cyc_addr",  32'(bus_if.cyc_addr),  32'h0);
    check("rst_cyc_wdata", 32'(bus_if.cyc_wdata), 32'h0);
    check("rst_err_late",  32'(bus_if.err_late),  32'h0);
    check("rst_state",     32'(dut.state),        32'(IDLE));
    rst = 1'b0;
    tick(2);

    // MEM_RD at 0x0123, response one cycle after acceptance.
    bus_if.a = 16'h0123;
    push(MEM_RD, 16'h0123, 8'h00);
    strobes(0, 1, 0, 1, 1);
    tick(3);
    check("mrd_valid_early", 32'(bus_if.cyc_valid), 32'h0);
    tick(1);
    check("mrd_valid_lat", 32'(bus_if.cyc_valid), 32'h1);
    check("mrd_wait_low",  32'(bus_if.wait_n),    32'(EXP_RD_WAIT));
    tick(1);
    respond(8'h5A);
    check("mrd_d_oe",    32'(bus_if.d_oe),   32'h1);
    check("mrd_d_out",   32'(bus_if.d_out),  32'h5A);
    check("mrd_wait_hi", 32'(bus_if.wait_n), 32'h1);
    tick(2);
    check("mrd_d_oe_hold", 32'(bus_if.d_oe), 32'h1);
    strobes(1, 1, 1, 1, 1);
    #1;
    check("mrd_d_oe_release", 32'(bus_if.d_oe), 32'h0);
    tick(4);
    check("mrd_idle", 32'(dut.state), 32'(IDLE));

    // IO_WR to port 0x03 with back-pressure before acceptance.
    bus_if.cyc_ready = 1'b0;
    bus_if.a = 16'hAB03;
    bus_if.d_in = 8'hC3;
    push(IO_WR, 16'hAB03, 8'hC3);
    strobes(1, 0, 1, 0, 1);
    tick(4);
    check("iowr_valid",  32'(bus_if.cyc_valid), 32'h1);
    check("iowr_wait_n", 32'(bus_if.wait_n),    32'h1);
    tick(2);
    check("iowr_hold_valid", 32'(bus_if.cyc_valid), 32'h1);
    check("iowr_hold_kind",  32'(bus_if.cyc_kind),  32'(IO_WR));
    check("iowr_hold_addr",  32'(bus_if.cyc_addr),  32'hAB03);
    bus_if.cyc_ready = 1'b1;
    tick(1);
    check("iowr_release_st", 32'(dut.state),   32'(RELEASE));
    check("iowr_d_oe",       32'(bus_if.d_oe), 32'h0);
    strobes(1, 1, 1, 1, 1);
    tick(4);
    check("iowr_idle", 32'(dut.state), 32'(IDLE));

    // MEM_RD just past the memory window.
    bus_if.a = 16'h2000;
    strobes(0, 1, 0, 1, 1);
    tick(5);
    check("oow_mem_state", 32'(dut.state),        32'(SKIP));
    check("oow_mem_valid", 32'(bus_if.cyc_valid), 32'h0);
    check("oow_mem_d_oe",  32'(bus_if.d_oe),      32'h0);
    check("oow_mem_wait",  32'(bus_if.wait_n),    32'h1);
    strobes(1, 1, 1, 1, 1);
    tick(4);
    check("oow_mem_idle", 32'(dut.state), 32'(IDLE));

    // IO read to unmatched port 0x10.
    bus_if.a = 16'h0010;
    strobes(1, 0, 0, 1, 1);
    tick(5);
    check("oow_io_state", 32'(dut.state),        32'(SKIP));
    check("oow_io_valid", 32'(bus_if.cyc_valid), 32'h0);
    strobes(1, 1, 1, 1, 1);
    tick(4);
    check("oow_io_idle", 32'(dut.state), 32'(IDLE));

    // Interrupt acknowledge pattern.
    bus_if.a = 16'h0001;
    strobes(0, 0, 1, 1, 0);
    tick(5);
    check("inta_state", 32'(dut.state),        32'(SKIP));
    check("inta_valid", 32'(bus_if.cyc_valid), 32'h0);
    check("inta_d_oe",  32'(bus_if.d_oe),      32'h0);
    strobes(1, 1, 1, 1, 1);
    tick(4);
    check("inta_idle", 32'(dut.state), 32'(IDLE));

    // Delayed response.
    bus_if.a = 16'h0040;
    push(MEM_RD, 16'h0040, 8'h00);
    strobes(0, 1, 0, 1, 1);
    tick(5);
`ifdef RC2014_WAIT_EN
    tick(4);
    check("wait_held",     32'(bus_if.wait_n),   32'h0);
    check("wait_state",    32'(dut.state),       32'(RESP));
    respond(8'h77);
    check("wait_released", 32'(bus_if.wait_n),   32'h1);
    check("wait_no_late",  32'(bus_if.err_late), 32'h0);
    check("wait_d_oe",     32'(bus_if.d_oe),     32'h1);
    strobes(1, 1, 1, 1, 1);
    tick(4);
    check("wait_idle", 32'(dut.state), 32'(IDLE));
`else
    strobes(1, 1, 1, 1, 1);
    tick(4);
    check("late_state",   32'(dut.state),       32'(LATE));
    check("late_pending", 32'(bus_if.err_late), 32'h0);
    check("late_d_oe",    32'(bus_if.d_oe),     32'h0);
    respond(8'h77);
    check("late_err",     32'(bus_if.err_late), 32'h1);
    check("late_d_oe2",   32'(bus_if.d_oe),     32'h0);
    check("late_idle",    32'(dut.state),       32'(IDLE));
    tick(3);
    check("late_sticky",  32'(bus_if.err_late), 32'h1);
`endif

    // Reset pulsed while driving a read at the top of the window.
    bus_if.a = 16'h1FFF;
    push(MEM_RD, 16'h1FFF, 8'h00);
    strobes(0, 1, 0, 1, 1);
    tick(5);
    respond(8'hA5);
    check("drv_d_oe",  32'(bus_if.d_oe),  32'h1);
    check("drv_d_out", 32'(bus_if.d_out), 32'hA5);
    #2;
    rst = 1'b1;
    #1;
    check("arst_d_oe",      32'(bus_if.d_oe),      32'h0);
    check("arst_d_out",     32'(bus_if.d_out),     32'h0);
    check("arst_err_late",  32'(bus_if.err_late),  32'h0);
    check("arst_wait_n",    32'(bus_if.wait_n),    32'h1);
    check("arst_cyc_addr",  32'(bus_if.cyc_addr),  32'h0);
    check("arst_state",     32'(dut.state),        32'(IDLE));
    strobes(1, 1, 1, 1, 1);
    tick(1);
    rst = 1'b0;
    tick(2);

    // Normal write at the bottom of the window after reset.
    bus_if.a = 16'h0000;
    bus_if.d_in = 8'h3C;
    push(MEM_WR, 16'h0000, 8'h3C);
    strobes(0, 1, 1, 0, 1);
    tick(4);
    check("post_valid", 32'(bus_if.cyc_valid), 32'h1);
    tick(1);
    strobes(1, 1, 1, 1, 1);
    tick(4);
    check("post_idle", 32'(dut.state), 32'(IDLE));

    check("sb_accepted", 32'(n_accepted), 32'(n_pushed));
    check("sb_empty",    32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
